// File: rtl/bitfusion_psum_accum.sv
// Per-lane reduction stage behind the fusion-unit column: re-aligns upstream valids to psum_fwd,
// accumulates each of the four lanes over len_reg samples and holds finished sums for a consumer.
module bitfusion_psum_accum #(
  parameter int unsigned COL_WIDTH = 9,
  parameter int unsigned ACC_WIDTH = 24,
  parameter int unsigned LAT       = 2,
  parameter int unsigned CNT_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cfg_load,
  input  logic [CNT_WIDTH-1:0]   cfg_len,
  input  logic                   cfg_signed,
  input  logic                   in_valid,
  input  logic [COL_WIDTH*4-1:0] psum_fwd,
  output logic                   in_stall,
  output logic [ACC_WIDTH*4-1:0] acc_out,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   busy,
  output logic                   overrun
);

  localparam int unsigned Lanes = 4;

  logic [LAT-1:0]                   dly_q, dly_d;
  logic [CNT_WIDTH-1:0]             count_q, count_d;
  logic [CNT_WIDTH-1:0]             len_q, len_d;
  logic                             signed_q, signed_d;
  logic [Lanes-1:0][ACC_WIDTH-1:0]  acc_q, acc_d;
  logic [Lanes-1:0][ACC_WIDTH-1:0]  out_q, out_d;
  logic                             out_valid_q, out_valid_d;
  logic                             overrun_q, overrun_d;

  logic [Lanes-1:0][COL_WIDTH-1:0]  lane_raw;
  logic [Lanes-1:0][ACC_WIDTH-1:0]  lane_ext;
  logic [Lanes-1:0][ACC_WIDTH-1:0]  lane_sum;
  logic                             pv;
  logic                             done;
  logic                             cfg_take;
  logic                             out_free;

  // Shift in_valid through LAT stages so pv lines up with the matching psum_fwd word.
  assign dly_d = LAT'({dly_q, in_valid});
  assign pv    = dly_q[LAT-1];

  assign busy     = (count_q != '0) || (dly_q != '0);
  assign cfg_take = cfg_load && !busy;
  assign done     = pv && (count_q == (len_q - CNT_WIDTH'(1)));
  assign out_free = !out_valid_q || out_ready;

  always_comb begin
    lane_raw = '0;
    lane_ext = '0;
    lane_sum = '0;
    for (int i = 0; i < Lanes; i++) begin
      lane_raw[i] = psum_fwd[i*COL_WIDTH +: COL_WIDTH];
      lane_ext[i] = signed_q ? ACC_WIDTH'($signed(lane_raw[i])) : ACC_WIDTH'(lane_raw[i]);
      // First sample of a result overwrites, so no stale partial sum can leak in.
      lane_sum[i] = (count_q == '0) ? lane_ext[i] : acc_q[i] + lane_ext[i];
    end
  end

  always_comb begin
    count_d = count_q;
    acc_d   = acc_q;
    if (pv) begin
      acc_d   = lane_sum;
      count_d = done ? '0 : count_q + CNT_WIDTH'(1);
    end
  end

  always_comb begin
    len_d       = len_q;
    signed_d    = signed_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    overrun_d   = overrun_q;
    if (cfg_take) begin
      len_d     = (cfg_len == '0) ? CNT_WIDTH'(1) : cfg_len;
      signed_d  = cfg_signed;
      overrun_d = 1'b0;
    end
    if (done) begin
      if (out_free) begin
        out_d       = lane_sum;
        out_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dly_q       <= '0;
      count_q     <= '0;
      len_q       <= CNT_WIDTH'(1);
      signed_q    <= 1'b0;
      acc_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      dly_q       <= dly_d;
      count_q     <= count_d;
      len_q       <= len_d;
      signed_q    <= signed_d;
      acc_q       <= acc_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign acc_out   = out_q;
  assign out_valid = out_valid_q;
  assign overrun   = overrun_q;
  assign in_stall  = out_valid_q && !out_ready;

endmodule

// File: tb/tb_bitfusion_psum_accum.sv
// Directed bench for bitfusion_psum_accum; a second instance with ACC_WIDTH=10 shares the
// stimulus so wrap-around can be observed on the same sequences.
module tb_bitfusion_psum_accum;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_load;
  logic [7:0]  cfg_len;
  logic        cfg_signed;
  logic        in_valid;
  logic [35:0] psum_fwd;
  logic        out_ready;

  logic        in_stall, out_valid, busy, overrun;
  logic [95:0] acc_out;
  logic        in_stall2, out_valid2, busy2, overrun2;
  logic [39:0] acc_out2;

  int errors = 0;
  int checks = 0;
  int first_ov;
  logic [95:0] first_acc;
  logic [35:0] samp [8];

  always #5 clk = ~clk;

  bitfusion_psum_accum #(.COL_WIDTH(9), .ACC_WIDTH(24), .LAT(LAT), .CNT_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_len(cfg_len), .cfg_signed(cfg_signed),
    .in_valid(in_valid), .psum_fwd(psum_fwd), .in_stall(in_stall), .acc_out(acc_out),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .overrun(overrun)
  );

  bitfusion_psum_accum #(.COL_WIDTH(9), .ACC_WIDTH(10), .LAT(LAT), .CNT_WIDTH(8)) dut_narrow (
    .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_len(cfg_len), .cfg_signed(cfg_signed),
    .in_valid(in_valid), .psum_fwd(psum_fwd), .in_stall(in_stall2), .acc_out(acc_out2),
    .out_valid(out_valid2), .out_ready(out_ready), .busy(busy2), .overrun(overrun2)
  );

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [35:0] pk(input logic [8:0] l3, input logic [8:0] l2,
                                     input logic [8:0] l1, input logic [8:0] l0);
    return {l3, l2, l1, l0};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [7:0] len, input logic sgn);
    cfg_len    = len;
    cfg_signed = sgn;
    cfg_load   = 1'b1;
    step();
    cfg_load   = 1'b0;
  endtask

  // Issue n valids back to back; psum word k is presented LAT cycles after its valid.
  // ld_at >= 0 pulses a cfg_load (len=1, signed) at that cycle, while the block is busy.
  task automatic run(input int n, input logic rdy, input int ld_at);
    first_ov  = -1;
    first_acc = '0;
    for (int c = 0; c < n + LAT; c++) begin
      in_valid  = (c < n);
      psum_fwd  = (c >= LAT) ? samp[c-LAT] : '0;
      out_ready = rdy;
      if (c == ld_at) begin
        check("busy_at_load", 96'(busy), 96'd1);
        cfg_len    = 8'd1;
        cfg_signed = 1'b1;
        cfg_load   = 1'b1;
      end else begin
        cfg_load   = 1'b0;
      end
      step();
      if (out_valid && first_ov < 0) begin
        first_ov  = c;
        first_acc = acc_out;
      end
    end
    in_valid = 1'b0;
    psum_fwd = '0;
    cfg_load = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cfg_load = 1'b0; cfg_len = '0; cfg_signed = 1'b0;
    in_valid = 1'b0; psum_fwd = '0; out_ready = 1'b1;
    step(); step();
    rst = 1'b0;
    check("rst_acc_out", acc_out, 96'd0);
    check("rst_out_valid", 96'(out_valid), 96'd0);
    check("rst_overrun", 96'(overrun), 96'd0);
    check("rst_busy", 96'(busy), 96'd0);
    check("rst_in_stall", 96'(in_stall), 96'd0);

    // Basic accumulate, four lanes with distinct patterns
    cfg(8'd4, 1'b0);
    for (int k = 0; k < 4; k++) samp[k] = pk(9'h1FF, 9'h100, 9'd5, 9'(k + 1));
    run(4, 1'b1, -1);
    check("basic_first_valid_cycle", 96'(first_ov), 96'd5);
    check("basic_acc", acc_out, {24'h0007FC, 24'h000400, 24'd20, 24'd10});
    step();
    check("basic_valid_one_cycle", 96'(out_valid), 96'd0);

    // Sign extension
    cfg(8'd3, 1'b1);
    for (int k = 0; k < 3; k++) samp[k] = pk(9'd0, 9'd0, 9'd0, 9'h1FF);
    run(3, 1'b1, -1);
    check("signed_acc", acc_out, {72'd0, 24'hFFFFFD});

    // Zero extension; narrow instance shows modulo-1024 wrap
    cfg(8'd3, 1'b0);
    run(3, 1'b1, -1);
    check("unsigned_acc", acc_out, {72'd0, 24'h0005FD});
    check("wrap_narrow_lane0", 96'(acc_out2[9:0]), 96'd509);

    // Backpressure: second completion is dropped and flagged
    cfg(8'd1, 1'b0);
    out_ready = 1'b0;
    in_valid = 1'b1; step();
    in_valid = 1'b0; step();
    in_valid = 1'b1; psum_fwd = pk(9'd0, 9'd0, 9'd0, 9'd7); step();
    check("bp_out_valid", 96'(out_valid), 96'd1);
    check("bp_in_stall", 96'(in_stall), 96'd1);
    check("bp_first_acc", acc_out, 96'd7);
    check("bp_no_overrun_yet", 96'(overrun), 96'd0);
    in_valid = 1'b0; psum_fwd = '0; step();
    psum_fwd = pk(9'd0, 9'd0, 9'd0, 9'd9); step();
    psum_fwd = '0;
    check("bp_overrun", 96'(overrun), 96'd1);
    check("bp_acc_held", acc_out, 96'd7);
    check("bp_idle", 96'(busy), 96'd0);
    cfg(8'd1, 1'b0);
    check("bp_cfg_clears_overrun", 96'(overrun), 96'd0);
    check("bp_still_held", acc_out, 96'd7);
    out_ready = 1'b1; step();
    check("bp_drained", 96'(out_valid), 96'd0);
    check("bp_stall_released", 96'(in_stall), 96'd0);

    // Reset mid-accumulation
    cfg(8'd4, 1'b0);
    in_valid = 1'b1; step(); step();
    in_valid = 1'b0; psum_fwd = pk(9'd0, 9'd0, 9'd0, 9'd100); step(); step();
    psum_fwd = '0;
    check("mid_busy", 96'(busy), 96'd1);
    rst = 1'b1; step(); rst = 1'b0;
    check("mid_rst_acc_out", acc_out, 96'd0);
    check("mid_rst_out_valid", 96'(out_valid), 96'd0);
    check("mid_rst_busy", 96'(busy), 96'd0);

    // Fresh accumulation with an ignored cfg_load while busy
    cfg(8'd4, 1'b0);
    for (int k = 0; k < 4; k++) samp[k] = pk(9'd0, 9'd0, 9'd0, 9'd1);
    run(4, 1'b1, 2);
    check("after_rst_first_valid", 96'(first_ov), 96'd5);
    check("after_rst_acc", acc_out, 96'd4);

    // cfg_len=0 acts as 1; back-to-back completions with simultaneous drain
    cfg(8'd0, 1'b0);
    samp[0] = pk(9'd0, 9'd0, 9'd0, 9'd3);
    samp[1] = pk(9'd2, 9'd0, 9'd0, 9'd5);
    run(2, 1'b1, -1);
    check("len0_first_valid", 96'(first_ov), 96'(LAT));
    check("len0_first_acc", first_acc, 96'd3);
    check("drain_complete_acc", acc_out, {24'd2, 24'd0, 24'd0, 24'd5});
    check("drain_complete_valid", 96'(out_valid), 96'd1);
    check("drain_complete_overrun", 96'(overrun), 96'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
